// File: rtl/queens_search_ctrl.sv
// Backtracking N-queens sequencer: row 0 fixed by the host, rows 1..N-1 searched
// one placement check per cycle in lexicographic column order.
`timescale 1ns/1ps
module queens_search_ctrl #(
    parameter int N      = 8,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              next,
    input  logic [2:0]        first_col,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [63:0]       board,
    output logic [6:0]        sol_cnt,
    output logic [STEP_W-1:0] steps
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_TRY, S_BACK, S_SOLVED, S_HOLD, S_EXH
    } state_t;

    localparam logic [3:0] N_L  = 4'(N);
    localparam logic [2:0] LAST = 3'(N - 1);

    state_t              state_q, state_d;
    logic [2:0]          col_q [8];
    logic [2:0]          col_d [8];
    logic [7:0]          placed_q, placed_d;
    logic [2:0]          cur_q, cur_d;
    logic [2:0]          first_q, first_d;
    logic                done_q, done_d;
    logic                found_q, found_d;
    logic [6:0]          sol_q, sol_d;
    logic [STEP_W-1:0]   steps_q, steps_d;

    logic                conflict;
    logic [2:0]          ccol;
    logic [2:0]          nxt_row;
    logic [2:0]          prv_row;
    logic                fc_legal;

    assign ccol     = col_q[cur_q];
    assign nxt_row  = cur_q + 3'd1;
    assign prv_row  = cur_q - 3'd1;
    assign fc_legal = ({1'b0, first_col} < N_L);

    function automatic logic [2:0] absdiff(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        return (&v) ? v : v + 7'd1;
    endfunction

    function automatic logic [STEP_W-1:0] sat_inc_steps(input logic [STEP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Only the row under test is checked against the rows above it.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) < cur_q) begin
                if (col_q[i] == ccol || absdiff(col_q[i], ccol) == (cur_q - 3'(i))) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        placed_d = placed_q;
        cur_d    = cur_q;
        first_d  = first_q;
        done_d   = 1'b0;
        found_d  = found_q;
        sol_d    = sol_q;
        steps_d  = steps_q;

        case (state_q)
            S_IDLE, S_HOLD: begin
                if (start) begin
                    if (fc_legal) begin
                        state_d = S_INIT;
                        first_d = first_col;
                        sol_d   = '0;
                        steps_d = '0;
                        found_d = 1'b0;
                    end else begin
                        state_d  = S_EXH;
                        placed_d = '0;
                        done_d   = 1'b1;
                        found_d  = 1'b0;
                    end
                end else if (state_q == S_HOLD && next) begin
                    // Resume as if the last row had just conflicted.
                    if (ccol < LAST) begin
                        col_d[cur_q] = ccol + 3'd1;
                        state_d      = S_TRY;
                    end else begin
                        state_d = S_BACK;
                    end
                end
            end
            S_INIT: begin
                col_d[0] = first_q;
                col_d[1] = 3'd0;
                placed_d = 8'b0000_0011;
                cur_d    = 3'd1;
                state_d  = S_TRY;
            end
            S_TRY: begin
                steps_d = sat_inc_steps(steps_q);
                if (!conflict) begin
                    if (cur_q == LAST) begin
                        state_d = S_SOLVED;
                        done_d  = 1'b1;
                        found_d = 1'b1;
                        sol_d   = sat_inc7(sol_q);
                    end else begin
                        cur_d             = nxt_row;
                        col_d[nxt_row]    = 3'd0;
                        placed_d[nxt_row] = 1'b1;
                    end
                end else if (ccol < LAST) begin
                    col_d[cur_q] = ccol + 3'd1;
                end else begin
                    state_d = S_BACK;
                end
            end
            S_BACK: begin
                placed_d[cur_q] = 1'b0;
                cur_d           = prv_row;
                if (prv_row == 3'd0) begin
                    // Clear the whole board so it already reads 0 on the done cycle.
                    state_d  = S_EXH;
                    placed_d = '0;
                    done_d   = 1'b1;
                    found_d  = 1'b0;
                end else if (col_q[prv_row] < LAST) begin
                    col_d[prv_row] = col_q[prv_row] + 3'd1;
                    state_d        = S_TRY;
                end
            end
            S_SOLVED: state_d = S_HOLD;
            S_EXH:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < 8; i++) begin
                col_q[i] <= '0;
            end
            placed_q <= '0;
            cur_q    <= '0;
            first_q  <= '0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            sol_q    <= '0;
            steps_q  <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            placed_q <= placed_d;
            cur_q    <= cur_d;
            first_q  <= first_d;
            done_q   <= done_d;
            found_q  <= found_d;
            sol_q    <= sol_d;
            steps_q  <= steps_d;
        end
    end

    always_comb begin
        board = '0;
        for (int r = 0; r < 8; r++) begin
            if (r < N && placed_q[r]) begin
                board[8*r +: 8] = 8'b1 << col_q[r];
            end
        end
    end

    assign ready   = (state_q == S_IDLE) || (state_q == S_HOLD);
    assign busy    = (state_q == S_INIT) || (state_q == S_TRY) || (state_q == S_BACK);
    assign done    = done_q;
    assign found   = found_q;
    assign sol_cnt = sol_q;
    assign steps   = steps_q;

endmodule

// File: doc/queens_search_ctrl.md
Name: queens_search_ctrl

Overview:
Backtracking sequencer for the N-queens board. Row 0 is fixed to a host-supplied column. The block then searches rows 1..N-1 one placement check per cycle, in lexicographic column order, until it finds a full placement or exhausts the search space. It owns the per-row column registers and drives the one-hot board bus that the display and safety-check logic consume. The host can step to the next solution without restarting.

Parameters:
N, 8, board size; legal range 4..8. Rows/columns at index >= N are unused and always read 0.
STEP_W, 16, width of the saturating check-step counter.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a new search; sampled only when ready=1
next  in  1  resume search for the next solution; sampled only in HOLD
first_col  in  3  column of the row-0 queen, sampled with start
ready  out  1  high in IDLE and HOLD
busy  out  1  high in INIT, TRY, BACK
done  out  1  one-cycle pulse: search finished (solution found or exhausted)
found  out  1  result of the last finished search; valid from the done cycle
board  out  64  bits [8r+7:8r] = one-hot column of row r; 0 if row r is not placed
sol_cnt  out  7  solutions reported since the last accepted start
steps  out  STEP_W  TRY evaluations since the last accepted start; saturates at all-ones

Behaviour:
- Reset (async): state=IDLE; all column/valid registers cleared; board=0, done=0, found=0, sol_cnt=0, steps=0; ready=1, busy=0.
- State registers: col[r] (3b) and placed[r] for each row; cur (3b) = row under test. board row r = placed[r] ? (1<<col[r]) : 0.
- Safety check (combinational, current row only): conflict if some i<cur has col[i]==col[cur] or |col[i]-col[cur]| == cur-i.
- IDLE:
  - start && first_col<N -> INIT. Clear sol_cnt, steps, found.
  - start && first_col>=N -> EXHAUSTED. No board change, found=0.
- INIT (1 cycle): col[0]=first_col; placed[0]=1; placed[1..7]=0; cur=1; col[1]=0; placed[1]=1 -> TRY.
- TRY (1 cycle per check; steps+=1, saturating):
  - safe, cur==N-1 -> SOLVED.
  - safe, cur<N-1 -> cur+1; col[cur+1]=0; placed[cur+1]=1; stay TRY.
  - conflict, col[cur]<N-1 -> col[cur]+1; stay TRY.
  - conflict, col[cur]==N-1 -> BACK.
- BACK (1 cycle per row popped): placed[cur]=0; cur-1.
  - new cur==0 -> EXHAUSTED.
  - col[new cur]<N-1 -> col+1 -> TRY.
  - otherwise stay BACK.
- SOLVED (1 cycle): done=1; found=1; sol_cnt+=1 (saturating at 127) -> HOLD.
- HOLD: board frozen on the solution; ready=1.
  - start -> restart as in IDLE. start wins if start and next are both high.
  - next -> resume exactly as a conflict at cur=N-1: advance col[N-1] if <N-1, else BACK.
- EXHAUSTED (1 cycle): done=1; found=0; placed[0..7]=0 (board=0); sol_cnt unchanged -> IDLE.
- start while busy and next outside HOLD are ignored with no side effects.
- first_col is sampled only on the accepted start cycle.
- Reset asserted mid-search aborts immediately to reset values. No done pulse is produced.
- Output timing: done/found are registered and change on the SOLVED/EXHAUSTED cycle. board reflects registers, i.e. the board value changes one cycle after the decision that changed it.

Test Plan:
- Reset, then idle 5 cycles -> board=0, ready=1, done never high, steps=0.
- N=8, start with first_col=0 -> done with found=1. Per-row columns 0,4,7,5,2,6,1,3: board row0=8'h01, row1=8'h10, row7=8'h08. sol_cnt=1. busy low from done onward.
- N=8, first_col=0, issue next after each done -> columns 0,5,7,2,6,3,1,4, then 0,6,3,5,7,1,4,2, then 0,6,4,7,1,3,5,2. The fifth done has found=0, board=0, sol_cnt=4, returns to IDLE.
- N=8, loop first_col 0..7, count solutions via next -> 4,8,16,18,18,16,8,4 (total 92). steps is monotonic and identical across repeated runs.
- N=4:
  - first_col=0 -> found=0.
  - first_col=1 -> columns 1,3,0,2.
  - first_col=5 -> done next cycle with found=0 and steps=0.
- Pulse start during busy, pulse next in IDLE, then assert rst mid-search -> ignored pulses leave the trajectory unchanged. Under rst all outputs take reset values immediately, with no done pulse.
